// File: rtl/bypass_buffer_pkg.sv
// Shared constants for the single-entry zero-latency bypass buffer.
package bypass_buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bypass_buffer.sv
// Single-entry buffer: data passes combinationally when the entry is empty and
// both sides transfer together; otherwise one word is held for the next cycle.
module bypass_buffer
    import bypass_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    output logic             full,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             empty
);

    logic             r_buffer_valid;
    logic [WIDTH-1:0] r_buffer_data;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_buffer_valid <= 1'b0;
            r_buffer_data  <= '0;
        end else if (r_buffer_valid) begin
            // A write while holding is only legal alongside a read; a lone write is dropped.
            if (read_enable) begin
                if (write_enable) begin
                    r_buffer_data <= write_data;
                end else begin
                    r_buffer_valid <= 1'b0;
                end
            end
        end else if (write_enable && !read_enable) begin
            r_buffer_data  <= write_data;
            r_buffer_valid <= 1'b1;
        end
    end

    assign empty     = !r_buffer_valid && !write_enable;
    assign full      = r_buffer_valid && !read_enable;
    assign read_data = r_buffer_valid ? r_buffer_data : write_data;

endmodule

// File: tb/tb_bypass_buffer.sv
// Randomised and directed checks of bypass_buffer against a capacity-one cut-through queue model.
module tb_bypass_buffer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         resetn;
    logic         write_enable;
    logic [W-1:0] write_data;
    logic         full;
    logic         read_enable;
    logic [W-1:0] read_data;
    logic         empty;

    always #5 clock = ~clock;

    bypass_buffer #(.WIDTH(W)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .write_enable (write_enable),
        .write_data   (write_data),
        .full         (full),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .empty        (empty)
    );

    int total   = 0;
    int bad     = 0;
    int n_reads = 0;

    // Words written but not yet read, oldest first.
    logic [W-1:0] model_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply enables, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic we, input logic re, input logic [W-1:0] wd);
        logic         empty_m;
        logic         full_m;
        logic         wacc;
        logic         racc;
        logic [W-1:0] exp_rd;
        @(negedge clock);
        write_enable = we;
        read_enable  = re;
        write_data   = wd;
        #1;
        empty_m = (model_q.size() == 0) && !we;
        full_m  = (model_q.size() != 0) && !re;
        wacc    = we && !full_m;
        racc    = re && !empty_m;
        chk("empty", empty, empty_m);
        chk("full", full, full_m);
        if (!racc && model_q.size() != 0)
            chk("hold_data", read_data, model_q[0]);
        if (wacc)
            model_q.push_back(wd);
        if (racc) begin
            exp_rd = model_q.pop_front();
            chk("read_data", read_data, exp_rd);
            n_reads++;
            $display("read #%0d: data=%0h expected=%0h we=%0b", n_reads, read_data, exp_rd, we);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn       = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        model_q.delete();
        #1;
        chk("reset_empty", empty, 1'b1);
        chk("reset_full", full, 1'b0);
    endtask

    initial begin
        int cycles;
        int start_reads;
        logic we;
        logic re;

        resetn       = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = '0;
        do_reset();

        // Bypass, then idle.
        cycle(1'b1, 1'b1, 8'hAA);
        cycle(1'b0, 1'b0, 8'h00);

        // Fill, hold for 10 idle cycles, drain.
        cycle(1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Protocol violations: lone write while full is ignored, lone read while empty changes nothing.
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h33);
        cycle(1'b0, 1'b0, 8'h00);

        // Alternating write then read.
        for (int n = 0; n < 100; n++) begin
            cycle(1'b1, 1'b0, W'(n));
            cycle(1'b0, 1'b1, 8'hFF);
        end

        // Continuous flow through an empty buffer.
        for (int n = 0; n < 100; n++) cycle(1'b1, 1'b1, W'(n));
        cycle(1'b0, 1'b0, 8'h00);

        // Continuous flow through a full buffer.
        cycle(1'b1, 1'b0, 8'h00);
        for (int n = 1; n <= 100; n++) cycle(1'b1, 1'b1, W'(n));
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Reset while holding a word drops it.
        cycle(1'b1, 1'b0, 8'h55);
        do_reset();
        cycle(1'b0, 1'b0, 8'h00);

        // Random legal traffic.
        start_reads = n_reads;
        cycles      = 0;
        while ((n_reads - start_reads) < 100 && cycles < 1000) begin
            if (model_q.size() == 0) begin
                we = 1'($urandom_range(0, 1));
                re = we && 1'($urandom_range(0, 1));
            end else begin
                re = 1'($urandom_range(0, 1));
                we = re && 1'($urandom_range(0, 1));
            end
            cycle(we, re, W'($urandom));
            cycles++;
        end
        if ((n_reads - start_reads) < 100)
            chk("random_timeout", n_reads - start_reads, 100);
        if (model_q.size() != 0) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("end_empty", empty, 1'b1);
        chk("end_full", full, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
